boot_loader: RTL and testbench
==============================

// Module: boot_loader
//
// PURPOSE
//  Copies a program image from ROM into RAM after reset, then releases the CPU.
//  Generalised successor to the fixed ROM->RAM bring-up path, adding:
//   - parametrised address/data width, image length and base addresses
//   - optional read-back verify pass, with a sticky error flag
//   - software re-boot request
//  Sits between ROM, RAM and CPU. Owns the RAM bus while cpu_hold=1.
//
// PARAMETERS
//  ADDR_W    `ADDR_SIZE  address bus width
//  WORD_W    `WORD_SIZE  data word width
//  PROG_LEN  16          words to copy (0..2**ADDR_W)
//  SRC_BASE  0           first ROM address of the image
//  DST_BASE  0           first RAM address of the destination
//  VERIFY    1           1 = read-back compare pass after copy; 0 = skip it
//
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  start        in   1       re-boot request pulse; sampled only in DONE/ERROR
//  rom_addr     out  ADDR_W  ROM read address
//  rom_data     in   WORD_W  ROM read data, combinational from rom_addr
//  ram_addr     out  ADDR_W  RAM address while cpu_hold=1
//  ram_wdata    out  WORD_W  RAM write data
//  ram_wr_en    out  1       RAM write strobe; RAM writes on rising clk
//  ram_rdata    in   WORD_W  RAM read data, combinational from ram_addr
//  cpu_hold     out  1       1 = CPU stalled and off the bus
//  boot_done    out  1       image loaded (and verified if VERIFY=1)
//  boot_err     out  1       verify mismatch; sticky until start or rst
//  words_done   out  ADDR_W+1  words processed in the current pass
//
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, all outputs 0 except cpu_hold=1.
//  FSM states: IDLE, COPY, VERIFY, DONE, ERROR.
//   - IDLE:   first clk edge with rst=0 -> COPY, idx=0. If PROG_LEN=0 -> DONE instead.
//   - COPY:   rom_addr = SRC_BASE+idx; ram_addr = DST_BASE+idx; ram_wdata = rom_data;
//             ram_wr_en = 1. idx++ each edge. At idx = PROG_LEN-1 the next edge goes to
//             VERIFY (VERIFY=1) or DONE (VERIFY=0), with idx=0.
//   - VERIFY: same addresses; ram_wr_en = 0. Each edge compares ram_rdata to rom_data.
//             Mismatch -> ERROR at that edge; idx stops advancing.
//             All PROG_LEN words match -> DONE.
//   - DONE:   cpu_hold=0, boot_done=1, ram_wr_en=0. start=1 -> COPY with idx=0;
//             boot_done and cpu_hold=1 take effect at the same edge.
//   - ERROR:  boot_err=1, cpu_hold=1, boot_done=0. start=1 -> COPY and boot_err clears.
//  Output timing:
//   - rom_addr, ram_addr, ram_wdata and ram_wr_en decode combinationally from state/idx.
//   - cpu_hold, boot_done and boot_err are registered.
//   - In IDLE/DONE/ERROR: addresses = 0, ram_wr_en = 0.
//  Latency: boot_done rises PROG_LEN+1 edges after reset release (VERIFY=0),
//   or 2*PROG_LEN+1 edges (VERIFY=1, clean image).
//  Address arithmetic is modulo 2**ADDR_W; a base+idx past the top wraps to 0.
//  words_done = idx in COPY/VERIFY; holds its final count in DONE/ERROR.
//  start is ignored in IDLE, COPY and VERIFY (no restart mid-pass).
//  rst mid-pass: immediate return to reset values. The partial RAM image is left as is;
//   the whole copy re-runs after release.
//
// TESTING
//  1. PROG_LEN=4, SRC_BASE=0x10, DST_BASE=0x20, ROM[0x10..0x13]=A1,A2,A3,A4, VERIFY=0
//     -> ram_wr_en high for 4 edges; RAM[0x20..0x23]=A1..A4; boot_done=1 and
//     cpu_hold=0 at edge 5.
//  2. Same image with VERIFY=1 -> 4 write edges, then 4 compare edges; boot_done at
//     edge 9; boot_err=0.
//  3. VERIFY=1, force ram_rdata=0x00 at address 0x22 -> ERROR at the 3rd verify edge;
//     boot_err=1, cpu_hold=1, words_done=2; then pulse start -> boot_err=0, copy re-runs.
//  4. DST_BASE=0xFE, PROG_LEN=4, ADDR_W=8 -> writes land at 0xFE,0xFF,0x00,0x01.
//  5. Assert rst at edge 2 of COPY -> outputs return to reset values that cycle;
//     after release a full 4-word copy completes; start pulsed during COPY has no effect.
//  6. PROG_LEN=0 -> no ram_wr_en pulses; boot_done=1 at the first edge after reset.

Source files
------------

// File: rtl/boot_loader_if.sv
// Bus bundle between the boot loader and its ROM, RAM and CPU-control
// neighbours.
//   master : the boot loader. It drives the ROM/RAM addresses, the RAM write
//            port, CPU hold and status. It receives start, rom_data and ram_rdata.
//   slave  : the system side. It drives start, rom_data and ram_rdata, and
//            receives everything else.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic              ram_wr_en;
  logic [WORD_W-1:0] ram_rdata;
  logic              cpu_hold;
  logic              boot_done;
  logic              boot_err;
  logic [ADDR_W:0]   words_done;

  modport master (
    input  start, rom_data, ram_rdata,
    output rom_addr, ram_addr, ram_wdata, ram_wr_en,
           cpu_hold, boot_done, boot_err, words_done
  );

  modport slave (
    output start, rom_data, ram_rdata,
    input  rom_addr, ram_addr, ram_wdata, ram_wr_en,
           cpu_hold, boot_done, boot_err, words_done
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader. After reset it copies PROG_LEN words of program image from ROM
// (starting at SRC_BASE) into RAM (starting at DST_BASE). It can then run an
// optional read-back verify pass before it releases the CPU.
//   clk, rst : system clock (rising edge); asynchronous active-high reset
//   bus      : boot_loader_if.master
//     start               re-boot request, honoured only in DONE/ERROR
//     rom_addr/rom_data   ROM read port (data combinational from address)
//     ram_addr/ram_wdata/ram_wr_en/ram_rdata   RAM port, owned while cpu_hold=1
//     cpu_hold            registered; 1 keeps the CPU stalled and off the bus
//     boot_done           registered; image loaded (and verified)
//     boot_err            registered; verify mismatch, sticky until start/rst
//     words_done          words processed in the current pass
module boot_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned PROG_LEN = 16,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 0,
  parameter bit          VERIFY   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  boot_loader_if.master bus
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LEN_C    = CNT_W'(PROG_LEN);
  localparam logic [CNT_W-1:0]  LAST_IDX = (PROG_LEN == 0) ? '0 : CNT_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic             cpu_hold_q;
  logic             boot_done_q;
  logic             boot_err_q;

  logic              active_c;
  logic [ADDR_W-1:0] off_c;

  // Sequencer. idx doubles as the words_done count. On a clean finish it is
  // parked at PROG_LEN, and after a mismatch it holds the failing word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cpu_hold_q  <= 1'b1;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          idx <= '0;
          if (PROG_LEN == 0) begin
            state       <= S_DONE;
            cpu_hold_q  <= 1'b0;
            boot_done_q <= 1'b1;
          end else begin
            state <= S_COPY;
          end
        end

        S_COPY: begin
          if (idx == LAST_IDX) begin
            if (VERIFY) begin
              state <= S_VERIFY;
              idx   <= '0;
            end else begin
              state       <= S_DONE;
              idx         <= LEN_C;
              cpu_hold_q  <= 1'b0;
              boot_done_q <= 1'b1;
            end
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end

        S_VERIFY: begin
          if (bus.ram_rdata != bus.rom_data) begin
            state      <= S_ERROR;
            boot_err_q <= 1'b1;
          end else if (idx == LAST_IDX) begin
            state       <= S_DONE;
            idx         <= LEN_C;
            cpu_hold_q  <= 1'b0;
            boot_done_q <= 1'b1;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end

        S_DONE: begin
          if (bus.start) begin
            state       <= S_COPY;
            idx         <= '0;
            cpu_hold_q  <= 1'b1;
            boot_done_q <= 1'b0;
          end
        end

        S_ERROR: begin
          if (bus.start) begin
            state      <= S_COPY;
            idx        <= '0;
            boot_err_q <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          idx         <= '0;
          cpu_hold_q  <= 1'b1;
          boot_done_q <= 1'b0;
          boot_err_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address decode. Base+offset wraps modulo 2**ADDR_W by truncation.
  assign active_c = (state == S_COPY) || (state == S_VERIFY);
  assign off_c    = idx[ADDR_W-1:0];

  assign bus.rom_addr   = active_c ? (SRC_A + off_c) : '0;
  assign bus.ram_addr   = active_c ? (DST_A + off_c) : '0;
  assign bus.ram_wdata  = bus.rom_data;
  assign bus.ram_wr_en  = (state == S_COPY);

  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.boot_done  = boot_done_q;
  assign bus.boot_err   = boot_err_q;
  assign bus.words_done = idx;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader. It runs three configurations side by side:
//   u_a : PROG_LEN=4, SRC=0x10, DST=0x20, VERIFY=1 (fault injection, re-boot, rst mid-pass)
//   u_b : PROG_LEN=4, SRC=0x10, DST=0xFE, VERIFY=0 (address wrap)
//   u_c : PROG_LEN=0                              (empty image)
module tb_boot_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned LEN    = 4;
  localparam int unsigned SRC    = 'h10;
  localparam int unsigned DST_A  = 'h20;
  localparam int unsigned DST_B  = 'hFE;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) if_a ();
  boot_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) if_b ();
  boot_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) if_c ();

  boot_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .PROG_LEN(LEN), .SRC_BASE(SRC),
                .DST_BASE(DST_A), .VERIFY(1'b1))
    u_a (.clk(clk), .rst(rst_a), .bus(if_a.master));
  boot_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .PROG_LEN(LEN), .SRC_BASE(SRC),
                .DST_BASE(DST_B), .VERIFY(1'b0))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b.master));
  boot_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .PROG_LEN(0), .SRC_BASE(SRC),
                .DST_BASE(DST_A), .VERIFY(1'b1))
    u_c (.clk(clk), .rst(rst_b), .bus(if_c.master));

  // Memory models
  logic [WORD_W-1:0] rom   [256];
  logic [WORD_W-1:0] ram_a [256];
  logic [WORD_W-1:0] ram_b [256];
  logic              mem_clr;
  logic              fault_en;
  logic [ADDR_W-1:0] fault_addr;
  logic [WORD_W-1:0] fault_val;
  int                wr_cnt_c = 0;

  assign if_a.rom_data  = rom[if_a.rom_addr];
  assign if_a.ram_rdata = (fault_en && if_a.ram_addr == fault_addr) ? fault_val : ram_a[if_a.ram_addr];
  assign if_b.rom_data  = rom[if_b.rom_addr];
  assign if_b.ram_rdata = ram_b[if_b.ram_addr];
  assign if_b.start     = 1'b0;
  assign if_c.rom_data  = '0;
  assign if_c.ram_rdata = '0;
  assign if_c.start     = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        ram_a[i] <= '0;
        ram_b[i] <= '0;
      end
    end else begin
      if (if_a.ram_wr_en) ram_a[if_a.ram_addr] <= if_a.ram_wdata;
      if (if_b.ram_wr_en) ram_b[if_b.ram_addr] <= if_b.ram_wdata;
    end
    if (if_c.ram_wr_en) wr_cnt_c <= wr_cnt_c + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on u_a for one edge.
  task automatic restart();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
  endtask

  // Run u_a until done/err rises, optionally pulsing start before edge sp.
  // edges = -1 if the budget expires.
  task automatic run_until_end(input int max_edges, input int sp, output int edges);
    edges = -1;
    for (int e = 1; e <= max_edges; e++) begin
      if_a.start = (e == sp);
      tick();
      if (if_a.boot_done || if_a.boot_err) begin
        edges = e;
        break;
      end
    end
    if_a.start = 1'b0;
  endtask

  typedef struct {
    logic       a_start;
    logic       a_wr;
    logic [7:0] a_ram;
    logic [7:0] a_rom;
    logic [8:0] a_words;
    logic       a_hold;
    logic       a_done;
    logic       b_wr;
    logic [7:0] b_ram;
    logic [8:0] b_words;
    logic       b_hold;
    logic       b_done;
  } vec_t;

  vec_t vec [10];
  logic [7:0] img [4];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int fidx;
    int sp;
    int exp_edges;

    img[0] = 8'hA1; img[1] = 8'hA2; img[2] = 8'hA3; img[3] = 8'hA4;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int j = 0; j < 4; j++) rom[SRC + j] = img[j];

    // Per-edge expectations after reset release (row k = state after edge k+1)
    vec[0] = '{1'b0, 1'b1, 8'h20, 8'h10, 9'd0, 1'b1, 1'b0, 1'b1, 8'hFE, 9'd0, 1'b1, 1'b0};
    vec[1] = '{1'b1, 1'b1, 8'h21, 8'h11, 9'd1, 1'b1, 1'b0, 1'b1, 8'hFF, 9'd1, 1'b1, 1'b0};
    vec[2] = '{1'b1, 1'b1, 8'h22, 8'h12, 9'd2, 1'b1, 1'b0, 1'b1, 8'h00, 9'd2, 1'b1, 1'b0};
    vec[3] = '{1'b0, 1'b1, 8'h23, 8'h13, 9'd3, 1'b1, 1'b0, 1'b1, 8'h01, 9'd3, 1'b1, 1'b0};
    vec[4] = '{1'b0, 1'b0, 8'h20, 8'h10, 9'd0, 1'b1, 1'b0, 1'b0, 8'h00, 9'd4, 1'b0, 1'b1};
    vec[5] = '{1'b1, 1'b0, 8'h21, 8'h11, 9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 9'd4, 1'b0, 1'b1};
    vec[6] = '{1'b0, 1'b0, 8'h22, 8'h12, 9'd2, 1'b1, 1'b0, 1'b0, 8'h00, 9'd4, 1'b0, 1'b1};
    vec[7] = '{1'b0, 1'b0, 8'h23, 8'h13, 9'd3, 1'b1, 1'b0, 1'b0, 8'h00, 9'd4, 1'b0, 1'b1};
    vec[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 9'd4, 1'b0, 1'b1, 1'b0, 8'h00, 9'd4, 1'b0, 1'b1};
    vec[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 9'd4, 1'b0, 1'b1, 1'b0, 8'h00, 9'd4, 1'b0, 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.start = 1'b0;
    fault_en = 1'b0;
    fault_addr = '0;
    fault_val = '0;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    tick();

    // Reset state
    check("rst_a_hold",  32'(if_a.cpu_hold), 32'd1);
    check("rst_a_done",  32'(if_a.boot_done), 32'd0);
    check("rst_a_err",   32'(if_a.boot_err), 32'd0);
    check("rst_a_wr",    32'(if_a.ram_wr_en), 32'd0);
    check("rst_a_words", 32'(if_a.words_done), 32'd0);
    check("rst_a_raddr", 32'(if_a.ram_addr), 32'd0);
    check("rst_a_rom",   32'(if_a.rom_addr), 32'd0);
    check("rst_b_hold",  32'(if_b.cpu_hold), 32'd1);
    check("rst_b_done",  32'(if_b.boot_done), 32'd0);
    check("rst_c_hold",  32'(if_c.cpu_hold), 32'd1);
    check("rst_c_done",  32'(if_c.boot_done), 32'd0);

    rst_a = 1'b0;
    rst_b = 1'b0;

    // Table: first boot of all three instances; start pulses on u_a mid-pass are ignored
    for (int i = 0; i < 10; i++) begin
      if_a.start = vec[i].a_start;
      tick();
      check($sformatf("a_wr[%0d]", i),    32'(if_a.ram_wr_en),  32'(vec[i].a_wr));
      check($sformatf("a_raddr[%0d]", i), 32'(if_a.ram_addr),   32'(vec[i].a_ram));
      check($sformatf("a_rom[%0d]", i),   32'(if_a.rom_addr),   32'(vec[i].a_rom));
      check($sformatf("a_words[%0d]", i), 32'(if_a.words_done), 32'(vec[i].a_words));
      check($sformatf("a_hold[%0d]", i),  32'(if_a.cpu_hold),   32'(vec[i].a_hold));
      check($sformatf("a_done[%0d]", i),  32'(if_a.boot_done),  32'(vec[i].a_done));
      check($sformatf("a_err[%0d]", i),   32'(if_a.boot_err),   32'd0);
      if (vec[i].a_wr)
        check($sformatf("a_wdata[%0d]", i), 32'(if_a.ram_wdata), 32'(rom[vec[i].a_rom]));
      check($sformatf("b_wr[%0d]", i),    32'(if_b.ram_wr_en),  32'(vec[i].b_wr));
      check($sformatf("b_raddr[%0d]", i), 32'(if_b.ram_addr),   32'(vec[i].b_ram));
      check($sformatf("b_rom[%0d]", i),   32'(if_b.rom_addr),   vec[i].b_wr ? 32'(vec[i].a_rom) : 32'd0);
      check($sformatf("b_words[%0d]", i), 32'(if_b.words_done), 32'(vec[i].b_words));
      check($sformatf("b_hold[%0d]", i),  32'(if_b.cpu_hold),   32'(vec[i].b_hold));
      check($sformatf("b_done[%0d]", i),  32'(if_b.boot_done),  32'(vec[i].b_done));
      if (vec[i].b_wr)
        check($sformatf("b_wdata[%0d]", i), 32'(if_b.ram_wdata), 32'(rom[vec[i].a_rom]));
      check($sformatf("c_done[%0d]", i),  32'(if_c.boot_done),  32'd1);
      check($sformatf("c_hold[%0d]", i),  32'(if_c.cpu_hold),   32'd0);
      check($sformatf("c_words[%0d]", i), 32'(if_c.words_done), 32'd0);
      check($sformatf("c_addr[%0d]", i),  32'(if_c.ram_addr) | 32'(if_c.rom_addr), 32'd0);
    end
    if_a.start = 1'b0;
    check("c_wr_pulses", 32'(wr_cnt_c), 32'd0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("ram_a[%0d]", j), 32'(ram_a[8'(DST_A + j)]), 32'(img[j]));
      check($sformatf("ram_b_wrap[%0d]", j), 32'(ram_b[8'(DST_B + j)]), 32'(img[j]));
    end

    // rst during COPY, then a full re-run after release
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    restart();
    check("reboot_hold", 32'(if_a.cpu_hold), 32'd1);
    check("reboot_done", 32'(if_a.boot_done), 32'd0);
    check("reboot_wr",   32'(if_a.ram_wr_en), 32'd1);
    tick();
    tick();
    #2 rst_a = 1'b1;
    #1;
    check("midrst_hold",  32'(if_a.cpu_hold), 32'd1);
    check("midrst_wr",    32'(if_a.ram_wr_en), 32'd0);
    check("midrst_words", 32'(if_a.words_done), 32'd0);
    check("midrst_raddr", 32'(if_a.ram_addr), 32'd0);
    check("midrst_partial", 32'(ram_a[8'(DST_A)]), 32'(img[0]));
    tick();
    rst_a = 1'b0;
    run_until_end(40, 3, e);
    check("rerun_edges", 32'(e), 32'd9);
    check("rerun_done",  32'(if_a.boot_done), 32'd1);
    for (int j = 0; j < 4; j++)
      check($sformatf("rerun_ram[%0d]", j), 32'(ram_a[8'(DST_A + j)]), 32'(img[j]));

    // Verify mismatch at 0x22, then recovery via start
    fault_en   = 1'b1;
    fault_addr = 8'h22;
    fault_val  = 8'h00;
    restart();
    run_until_end(40, 0, e);
    check("err_edges", 32'(e), 32'd7);
    check("err_flag",  32'(if_a.boot_err), 32'd1);
    check("err_hold",  32'(if_a.cpu_hold), 32'd1);
    check("err_done",  32'(if_a.boot_done), 32'd0);
    check("err_words", 32'(if_a.words_done), 32'd2);
    tick();
    tick();
    check("err_sticky", 32'(if_a.boot_err), 32'd1);
    check("err_words_hold", 32'(if_a.words_done), 32'd2);
    fault_en = 1'b0;
    restart();
    check("err_clear", 32'(if_a.boot_err), 32'd0);
    check("err_clear_hold", 32'(if_a.cpu_hold), 32'd1);
    run_until_end(40, 0, e);
    check("recover_edges", 32'(e), 32'd8);
    check("recover_done",  32'(if_a.boot_done), 32'd1);
    check("recover_hold",  32'(if_a.cpu_hold), 32'd0);

    // Randomised images, faults and stray start pulses against a rule-level model
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 4; j++) rom[SRC + j] = 8'($urandom);
      fidx       = int'($urandom_range(0, LEN - 1));
      fault_en   = ($urandom_range(0, 1) == 1);
      fault_addr = 8'(DST_A + fidx);
      fault_val  = rom[SRC + fidx] ^ 8'($urandom_range(1, 255));
      sp         = int'($urandom_range(0, 2 * LEN - 2));
      restart();
      run_until_end(40, sp, e);
      exp_edges = fault_en ? int'(LEN) + fidx + 1 : 2 * int'(LEN);
      check($sformatf("rnd%0d_edges", it), 32'(e), 32'(exp_edges));
      check($sformatf("rnd%0d_err", it),   32'(if_a.boot_err), 32'(fault_en));
      check($sformatf("rnd%0d_done", it),  32'(if_a.boot_done), 32'(!fault_en));
      check($sformatf("rnd%0d_hold", it),  32'(if_a.cpu_hold), 32'(fault_en));
      check($sformatf("rnd%0d_words", it), 32'(if_a.words_done), fault_en ? 32'(fidx) : 32'(LEN));
      for (int j = 0; j < 4; j++)
        check($sformatf("rnd%0d_ram[%0d]", it, j), 32'(ram_a[8'(DST_A + j)]), 32'(rom[SRC + j]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
